// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw bouncy input into the clk domain and
// accepts a level change only after DB_CYCLES consecutive clock edges of
// disagreement with the current debounced level.
// Optional feature: define BTN_DEBOUNCE_GLITCH_CNT_EN to add the saturating
// glitch_cnt output, which counts qualifications abandoned by a bounce.
module btn_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 20,
   parameter int DB_CYCLES   = 500000,
   parameter int GLITCH_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                d_in,
   output logic                db_out,
   output logic                busy
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
   ,output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Reject illegal configurations at elaboration time.
   if (SYNC_STAGES < 2 || DB_CYCLES < 1 || GLITCH_W < 1 ||
       (DB_CYCLES >> CNT_W) != 0) begin : g_bad_params
      $error("btn_debounce: illegal parameter combination");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_q;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   db_q, db_d;

   assign s_q    = sync_q[SYNC_STAGES-1];
   assign db_out = db_q;

   // Plain flop chain for metastability settling; nothing between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      end
   end

   // State register together with the stability counter and debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         db_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   // Next state: count consecutive disagreeing edges, toggle on the last one,
   // and drop back to IDLE with a cleared count on any agreement.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      unique case (state_q)
         IDLE: begin
            if (s_q != db_q) begin
               if (DB_CYCLES == 1) begin
                  db_d = ~db_q;
               end else begin
                  cnt_d   = CNT_ONE;
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (s_q != db_q) begin
               if (cnt_q == CNT_LAST) begin
                  db_d    = ~db_q;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode from the state register only, never from d_in.
   always_comb begin
      busy = (state_q == PEND);
   end

`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
   logic                bounce;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;

   assign bounce     = (state_q == PEND) && (s_q == db_q);
   assign glitch_cnt = glitch_q;

   // Saturating count of bounces; a completed toggle never counts.
   always_comb begin
      glitch_d = glitch_q;
      if (bounce && (glitch_q != {GLITCH_W{1'b1}})) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end
   end

   // Glitch counter register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end
`endif

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioning stage sitting directly upstream of the rise/fall edge detector. Takes a raw, asynchronous, bouncy input (push-button or switch), synchronizes it into the `clk` domain, and accepts a level change only after it has been stable for a programmable number of cycles. The clean `db_out` level drives the edge detector's `d_in`, so each physical press yields exactly one rise pulse and one fall pulse.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops. Legal range is 2 or more.
- `CNT_W`, default 20: width of the stability counter.
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a change. Legal range is 1 ≤ `DB_CYCLES` ≤ 2^`CNT_W`−1.
- `GLITCH_W`, default 8: width of the glitch counter. Used only with `BTN_DEBOUNCE_GLITCH_CNT_EN`.
- `clk` — input, 1 bit: clock.
- `rst` — input, 1 bit: reset, asynchronous, active-high.
- `d_in` — input, 1 bit: raw asynchronous input.
- `db_out` — output, 1 bit: debounced level, registered.
- `busy` — output, 1 bit: high while a candidate change is being qualified.
- `glitch_cnt` — output, `GLITCH_W` bits: count of rejected bounces. Present only with the macro.

## Operation
- **Synchronizer.** A chain of `SYNC_STAGES` flops samples `d_in`. `s_q` is the last stage. No logic is placed between stages.
- **State machine.** Two states.
  - IDLE: `s_q == db_out`, `cnt == 0`.
  - PEND: counting.
- **Transitions** (evaluated each `clk` edge):
  - IDLE, `s_q != db_out`:
    - If `DB_CYCLES == 1`: toggle `db_out` and stay in IDLE.
    - Otherwise: `cnt <= 1` and go to PEND.
  - IDLE, `s_q == db_out`: hold.
  - PEND, `s_q != db_out`, `cnt == DB_CYCLES-1`: `db_out <= ~db_out`, `cnt <= 0`, go to IDLE.
  - PEND, `s_q != db_out`, `cnt < DB_CYCLES-1`: `cnt <= cnt+1`.
  - PEND, `s_q == db_out` (bounce): `cnt <= 0`, go to IDLE. The glitch counter increments when enabled.
- **Toggle rule.** `db_out` toggles on the `DB_CYCLES`-th consecutive edge at which `s_q != db_out`. Any return of `s_q` to `db_out` restarts qualification from zero.
- **Outputs.**
  - `busy` = (state == PEND), decoded from the state register with no combinational path from `d_in`.
  - `db_out` is a flop output.
- **Counter.** `cnt` never exceeds `DB_CYCLES-1` and never wraps.
- **Reset** (asynchronous, takes effect immediately, including mid-qualification):
  - All sync flops = 0, `db_out` = 0, `busy` = 0, `cnt` = 0, state = IDLE, `glitch_cnt` = 0.
  - After release, a `d_in` held at 1 is qualified like any other change.

## Timing
- Latency from a clean `d_in` change to the `db_out` change is exactly `SYNC_STAGES + DB_CYCLES` rising edges.
  - Edge 1 is the first edge sampling the new value.
  - `db_out` changes after edge `SYNC_STAGES + DB_CYCLES`.
- `busy` rises one edge after `s_q` first differs. It falls on the same edge `db_out` toggles, or on the bounce edge.
- Pulses on `d_in` shorter than `DB_CYCLES` cycles, as seen at `s_q`, never reach `db_out`.
- The maximum `db_out` toggle rate is one toggle per `DB_CYCLES` cycles.
- Downstream, the edge detector fires its pulse in the same cycle `db_out` changes. No extra alignment is required.

## Configuration
- Macro: `BTN_DEBOUNCE_GLITCH_CNT_EN`.
- Defined:
  - `glitch_cnt` port exists.
  - It increments by 1 on every PEND→IDLE bounce transition.
  - It saturates at 2^`GLITCH_W`−1 and is cleared only by `rst`.
  - A completed toggle does not increment it.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DB_CYCLES`=4, `GLITCH_W`=2.
- **Reset values.** Assert `rst` with `d_in`=1 → `db_out`=0, `busy`=0, `glitch_cnt`=0 immediately, without waiting for a clock edge.
- **Clean rise.** Release reset with `d_in`=0, then step `d_in` to 1 and hold → `db_out`=1 exactly 6 edges later. `busy` is high for edges 3–5 of the window.
- **Bounce rejection.** `d_in` = 1 for 2 cycles, then 0 for 1, then held at 1 → `db_out` is not set after 6 edges. It rises 6 edges after the final step. `glitch_cnt`=1.
- **Glitch saturation.** Apply 5 pulses of 2 cycles each from a stable 0 → `db_out` stays 0 and `glitch_cnt` reads 3.
- **Clean fall.** From `db_out`=1, drop `d_in` to 0 → `db_out`=0 after 6 edges. The downstream edge detector produces exactly one `fall_edge` pulse.
- **Reset mid-qualification.** Assert `rst` while `busy`=1 with `cnt`=2 → `db_out`=0 and `busy`=0 at once. After release with `d_in`=1, `db_out`=1 after a full 6 edges.
